pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central pipeline controller for the 5-stage RV32I core. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. Each cycle it produces per-stage enable and flush controls from three sources: load-use hazard detection, branch/jump redirects resolved in EX, and LSU request/acknowledge wait states. It also keeps stall/flush performance counters and a sticky memory-timeout flag.

## Interface
- CNT_W, 16, width of the saturating performance counters
- MEM_TIMEOUT, 64, number of MEM_WAIT cycles after which o_mem_timeout sets (≥1)

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_id_vld  in  1  ID stage holds a valid instruction
- i_id_instr  in  32  instruction in ID
- i_ex_vld  in  1  EX stage holds a valid instruction
- i_ex_is_load  in  1  EX instruction is a load
- i_ex_rd_addr  in  5  EX destination register
- i_ex_br_taken  in  1  EX resolved a taken branch or jump (PC redirect)
- i_mem_req  in  1  MEM stage is issuing an LSU access this cycle
- i_mem_ack  in  1  LSU completes the access this cycle
- o_pc_en  out  1  PC update enable
- o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en  out  1 each  register load enables
- o_if_id_flush, o_id_ex_flush  out  1 each  load NOP (instr 0x00000013, all control 0, insn_vld 0) in place of the input
- o_state  out  2  FSM state: 0 RUN, 1 LDUSE, 2 MEM_WAIT
- o_stall_cnt  out  CNT_W  cycles with o_pc_en=0
- o_flush_cnt  out  CNT_W  branch-flush events
- o_mem_timeout  out  1  sticky: a MEM_WAIT reached MEM_TIMEOUT cycles

## Operation
- Hazard decode from i_id_instr: rs1=[19:15], rs2=[24:20], opcode=[6:0].
  - rs1 is used unless opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
  - rs2 is used only for opcodes 0110011, 0100011 and 1100011.
- Load-use hazard (LU) = i_id_vld & i_ex_vld & i_ex_is_load & (i_ex_rd_addr≠0) & (used rs1 or used rs2 equals i_ex_rd_addr).
- Memory hold MH = i_mem_req & ~i_mem_ack.
- Default controls: every enable 1, every flush 0.
- RUN and LDUSE use the same response, applied in this priority order:
  1. MH: all enables 0, flushes 0; next state MEM_WAIT.
  2. i_ex_br_taken: o_if_id_flush=1, o_id_ex_flush=1, enables 1; o_flush_cnt++. LU is ignored because ID is on the wrong path. Next state RUN.
  3. LU, in RUN only: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, other enables 1; next state LDUSE.
  4. Otherwise: default controls; next state RUN.
- In LDUSE, LU is not re-evaluated: exactly one bubble is inserted per load, and forwarding covers the remainder.
- MEM_WAIT:
  - While i_mem_ack=0: all enables 0 and flushes 0. The wait counter increments, saturating at MEM_TIMEOUT. On reaching MEM_TIMEOUT, o_mem_timeout sets. The state remains MEM_WAIT.
  - On i_mem_ack=1: evaluate RUN rules 2–4 with MH treated as 0. A branch or load-use held during the wait is acted on in that same cycle. The wait counter clears.
- Flush is only ever asserted together with its register's enable=1.
- Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- All enables and flushes are combinational from the current state and inputs, so a stall takes effect at the same clock edge. Counters, state and the timeout flag are registered.
- While i_rst_n=0, independent of clock: state RUN, o_stall_cnt=0, o_flush_cnt=0, wait counter 0, o_mem_timeout=0. Outputs are driven as in RUN with all inputs 0, i.e. enables 1 and flushes 0.
- Asserting reset in the middle of MEM_WAIT or LDUSE returns to RUN immediately. No pending branch or hazard is remembered.
- Load-use costs exactly 1 bubble cycle. A branch costs 2 flushed slots with no stall cycle.
- MEM_WAIT of N ack-less cycles stalls N cycles. i_mem_ack in the same cycle as i_mem_req gives zero stall.
- Simultaneous MH, branch and LU: MH wins. The branch flush is applied in the ack cycle.
- o_stall_cnt counts every cycle with o_pc_en=0, covering both LU and MEM_WAIT cycles.

## Test plan
- LU: EX holds a load to x5 and ID holds add x6,x5,x7 (0x00728333) → one cycle with o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1; then LDUSE; then RUN; o_stall_cnt=1.
- No false hazard: EX loads x0, or ID holds lui x5,1 with EX load to x5 → no stall, state stays RUN.
- Branch: i_ex_br_taken=1 together with an LU condition → both flushes 1, o_pc_en=1, o_flush_cnt=1, no LDUSE entry.
- Memory wait: i_mem_req=1 with ack delayed 3 cycles → 3 cycles with all enables 0; a branch pending during the wait flushes in the ack cycle; o_stall_cnt=3.
- Timeout: MEM_TIMEOUT=4 with ack withheld for 6 cycles → o_mem_timeout=1 from the 4th wait cycle and remains 1 after the ack until reset.
- Reset mid-wait: drop i_rst_n during MEM_WAIT → o_state=0, both counters 0 and o_mem_timeout=0 without a clock edge. Counter saturation is checked with CNT_W=4: after 20 stall cycles o_stall_cnt=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// pipe_hazard_ctrl
// Central pipeline controller for the 5-stage RV32I core. Every cycle it
// derives the PC / pipeline-register enables and the IF/ID, ID/EX flushes
// from three sources: load-use hazards, EX-resolved branch redirects, and
// LSU request/acknowledge wait states. It also keeps saturating stall/flush
// counters and a sticky memory-timeout flag.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_id_vld, i_id_instr    instruction currently in ID
//   i_ex_vld, i_ex_is_load,
//   i_ex_rd_addr            instruction currently in EX
//   i_ex_br_taken           EX redirects the PC this cycle
//   i_mem_req, i_mem_ack    LSU access issued / completed this cycle
//   o_pc_en, o_*_en         PC and pipeline register load enables
//   o_if_id_flush,
//   o_id_ex_flush           load a NOP instead of the register input
//   o_state                 0 RUN, 1 LDUSE, 2 MEM_WAIT
//   o_stall_cnt             cycles with o_pc_en = 0 (saturating)
//   o_flush_cnt             branch-flush events (saturating)
//   o_mem_timeout           sticky: a memory wait lasted MEM_TIMEOUT cycles
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_vld,
  input  logic [31:0]      i_id_instr,
  input  logic             i_ex_vld,
  input  logic             i_ex_is_load,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_br_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_id_ex_en,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic             o_mem_timeout
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LDUSE    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } ctl_t;

  localparam ctl_t CTL_DEFAULT = 7'b11111_00;
  localparam ctl_t CTL_HOLD    = 7'b00000_00;
  localparam ctl_t CTL_BRANCH  = 7'b11111_11;
  // Freeze PC and IF/ID, turn the ID/EX slot into a bubble, let EX..WB drain.
  localparam ctl_t CTL_LDUSE   = 7'b00111_01;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRAN  = 7'b1100011;

  localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              timeout_q, timeout_d;
  ctl_t              ctl;

  // Hazard decode
  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       rs1_used, rs2_used, lu_hazard, mem_hold;
  logic       unused_instr_bits;

  assign opcode   = i_id_instr[6:0];
  assign rs1      = i_id_instr[19:15];
  assign rs2      = i_id_instr[24:20];
  assign rs1_used = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign rs2_used = opcode inside {OP_OP, OP_STORE, OP_BRAN};

  // Remaining instruction fields play no part in hazard detection.
  assign unused_instr_bits = ^{i_id_instr[31:25], i_id_instr[14:7]};

  assign lu_hazard = i_id_vld & i_ex_vld & i_ex_is_load & (i_ex_rd_addr != 5'd0)
                   & ((rs1_used & (rs1 == i_ex_rd_addr)) | (rs2_used & (rs2 == i_ex_rd_addr)));
  assign mem_hold  = i_mem_req & ~i_mem_ack;

  // State register, counters and timeout flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values of its peers, independent of statement order.
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the
    // variable unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_RUN, ST_LDUSE: begin
        if (mem_hold)                               state_d = ST_MEM_WAIT;
        else if (i_ex_br_taken)                     state_d = ST_RUN;
        else if (lu_hazard && (state_q == ST_RUN))  state_d = ST_LDUSE;
        else                                        state_d = ST_RUN;
      end
      ST_MEM_WAIT: begin
        // A branch or load-use held across the wait is resolved in the ack cycle.
        if (!i_mem_ack)         state_d = ST_MEM_WAIT;
        else if (i_ex_br_taken) state_d = ST_RUN;
        else if (lu_hazard)     state_d = ST_LDUSE;
        else                    state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output logic: enables and flushes are combinational so a stall hits
  // the same clock edge.
  always_comb begin
    ctl = CTL_DEFAULT;
    unique case (state_q)
      ST_RUN, ST_LDUSE: begin
        if (mem_hold)                               ctl = CTL_HOLD;
        else if (i_ex_br_taken)                     ctl = CTL_BRANCH;
        else if (lu_hazard && (state_q == ST_RUN))  ctl = CTL_LDUSE;
      end
      ST_MEM_WAIT: begin
        if (!i_mem_ack)         ctl = CTL_HOLD;
        else if (i_ex_br_taken) ctl = CTL_BRANCH;
        else if (lu_hazard)     ctl = CTL_LDUSE;
      end
      default: ctl = CTL_DEFAULT;
    endcase
    // While reset is held the pipeline sees plain RUN controls whatever the
    // inputs are doing.
    if (!i_rst_n) ctl = CTL_DEFAULT;
  end

  // Counter and timeout next-state
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = '0;
    if (!ctl.pc_en && (stall_cnt_q != '1))  stall_cnt_d = stall_cnt_q + CNT_W'(1);
    // IF/ID flush is asserted only for a branch redirect.
    if (ctl.if_id_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if ((state_q == ST_MEM_WAIT) && !i_mem_ack) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end
    timeout_d = timeout_q | (wait_cnt_d == WAIT_MAX);
  end

  assign o_pc_en       = ctl.pc_en;
  assign o_if_id_en    = ctl.if_id_en;
  assign o_id_ex_en    = ctl.id_ex_en;
  assign o_ex_mem_en   = ctl.ex_mem_en;
  assign o_mem_wb_en   = ctl.mem_wb_en;
  assign o_if_id_flush = ctl.if_id_flush;
  assign o_id_ex_flush = ctl.id_ex_flush;
  assign o_state       = state_q;
  assign o_stall_cnt   = stall_cnt_q;
  assign o_flush_cnt   = flush_cnt_q;
  assign o_mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// Bench for pipe_hazard_ctrl. Two instances share all inputs: dut uses the
// default parameters, dut_s uses CNT_W=4 / MEM_TIMEOUT=4 for the timeout and
// saturation scenarios. Expected per-cycle controls are queued as stimulus is
// driven and compared on the following falling edge.
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] I_ADD   = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] I_SW    = 32'h00532023; // sw   x5,0(x6)
  localparam logic [31:0] I_ADDI  = 32'h00538313; // addi x6,x7,5
  localparam logic [31:0] I_ADD0  = 32'h00700333; // add  x6,x0,x7
  localparam logic [31:0] I_LUI1  = 32'h000012B7; // lui  x5,1
  localparam logic [31:0] I_LUI   = 32'h000282B7; // lui  x5,0x28 (rs1 field = 5)
  localparam logic [31:0] I_AUIPC = 32'h00028297; // auipc x5,0x28 (rs1 field = 5)
  localparam logic [31:0] I_JAL   = 32'h000280EF; // jal with rs1 field = 5

  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id flush, id_ex flush}
  localparam logic [6:0] C_DEF  = 7'b11111_00;
  localparam logic [6:0] C_HOLD = 7'b00000_00;
  localparam logic [6:0] C_LU   = 7'b00111_01;
  localparam logic [6:0] C_BR   = 7'b11111_11;

  localparam logic [1:0] S_RUN = 2'd0, S_LDU = 2'd1, S_MW = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_vld, ex_vld, ex_is_load, ex_br_taken, mem_req, mem_ack;
  logic [31:0] id_instr;
  logic [4:0]  ex_rd_addr;

  logic        a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en, a_if_id_flush, a_id_ex_flush;
  logic [1:0]  a_state;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        a_mem_timeout;

  logic        b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en, b_if_id_flush, b_id_ex_flush;
  logic [1:0]  b_state;
  logic [3:0]  b_stall_cnt, b_flush_cnt;
  logic        b_mem_timeout;

  logic [6:0]  a_ctl, b_ctl;
  assign a_ctl = {a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en, a_if_id_flush, a_id_ex_flush};
  assign b_ctl = {b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en, b_if_id_flush, b_id_ex_flush};

  pipe_hazard_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_vld(id_vld), .i_id_instr(id_instr),
    .i_ex_vld(ex_vld), .i_ex_is_load(ex_is_load), .i_ex_rd_addr(ex_rd_addr),
    .i_ex_br_taken(ex_br_taken), .i_mem_req(mem_req), .i_mem_ack(mem_ack),
    .o_pc_en(a_pc_en), .o_if_id_en(a_if_id_en), .o_id_ex_en(a_id_ex_en),
    .o_ex_mem_en(a_ex_mem_en), .o_mem_wb_en(a_mem_wb_en),
    .o_if_id_flush(a_if_id_flush), .o_id_ex_flush(a_id_ex_flush),
    .o_state(a_state), .o_stall_cnt(a_stall_cnt), .o_flush_cnt(a_flush_cnt),
    .o_mem_timeout(a_mem_timeout)
  );

  pipe_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_vld(id_vld), .i_id_instr(id_instr),
    .i_ex_vld(ex_vld), .i_ex_is_load(ex_is_load), .i_ex_rd_addr(ex_rd_addr),
    .i_ex_br_taken(ex_br_taken), .i_mem_req(mem_req), .i_mem_ack(mem_ack),
    .o_pc_en(b_pc_en), .o_if_id_en(b_if_id_en), .o_id_ex_en(b_id_ex_en),
    .o_ex_mem_en(b_ex_mem_en), .o_mem_wb_en(b_mem_wb_en),
    .o_if_id_flush(b_if_id_flush), .o_id_ex_flush(b_id_ex_flush),
    .o_state(b_state), .o_stall_cnt(b_stall_cnt), .o_flush_cnt(b_flush_cnt),
    .o_mem_timeout(b_mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] ctl;
    logic [1:0] st;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_stall, exp_flush;
  logic [3:0]  exp_stall_s, exp_flush_s;

  // Scoreboard comparator: one queued expectation per driven cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      checks += 3;
      if (a_ctl !== sb_e.ctl) begin
        failures++;
        $display("FAIL ctl_main t=%0t got=%b want=%b", $time, a_ctl, sb_e.ctl);
      end
      if (b_ctl !== sb_e.ctl) begin
        failures++;
        $display("FAIL ctl_small t=%0t got=%b want=%b", $time, b_ctl, sb_e.ctl);
      end
      if (a_state !== sb_e.st) begin
        failures++;
        $display("FAIL state t=%0t got=%0d want=%0d", $time, a_state, sb_e.st);
      end
    end
  end

  // Drive one cycle of inputs and queue the expected controls/state.
  task automatic cyc(input logic idv, input logic [31:0] ins, input logic exv, input logic exl,
                     input logic [4:0] rd, input logic br, input logic req, input logic ack,
                     input logic [6:0] ctl, input logic [1:0] st);
    @(posedge clk); #1;
    id_vld = idv; id_instr = ins; ex_vld = exv; ex_is_load = exl; ex_rd_addr = rd;
    ex_br_taken = br; mem_req = req; mem_ack = ack;
    sb_q.push_back('{ctl: ctl, st: st});
    if (!ctl[6]) begin
      if (exp_stall != 16'hFFFF) exp_stall += 16'd1;
      if (exp_stall_s != 4'hF)   exp_stall_s += 4'd1;
    end
    if (ctl[1]) begin
      if (exp_flush != 16'hFFFF) exp_flush += 16'd1;
      if (exp_flush_s != 4'hF)   exp_flush_s += 4'd1;
    end
  endtask

  task automatic idle(input logic [1:0] st);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_DEF, st);
  endtask

  task automatic test_reset;
    #2;
    checks += 6;
    if (a_ctl !== C_DEF || b_ctl !== C_DEF) begin
      failures++; $display("FAIL reset_ctl got=%b/%b want=%b", a_ctl, b_ctl, C_DEF);
    end
    if (a_state !== S_RUN) begin failures++; $display("FAIL reset_state got=%0d want=0", a_state); end
    if (a_stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d want=0", a_stall_cnt); end
    if (a_flush_cnt !== 16'd0) begin failures++; $display("FAIL reset_flush got=%0d want=0", a_flush_cnt); end
    if (a_mem_timeout !== 1'b0 || b_mem_timeout !== 1'b0) begin
      failures++; $display("FAIL reset_timeout got=%b/%b want=0", a_mem_timeout, b_mem_timeout);
    end
    if (b_stall_cnt !== 4'd0 || b_flush_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_small_cnt got=%0d/%0d want=0/0", b_stall_cnt, b_flush_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load_use;
    // rs1 hazard (add x6,x5,x7), LU held in LDUSE must not re-stall
    cyc(1'b1, I_ADD, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU, S_RUN);
    cyc(1'b1, I_ADD, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_DEF, S_LDU);
    idle(S_RUN);
    @(negedge clk);
    checks++;
    if (a_stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d want=1", a_stall_cnt); end
    // rs2 hazard via store
    cyc(1'b1, I_SW, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU, S_RUN);
    idle(S_LDU);
    // rs1 hazard on I-type, then rs2 field of I-type ignored
    cyc(1'b1, I_ADDI, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_LU, S_RUN);
    idle(S_LDU);
    cyc(1'b1, I_ADDI, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_DEF, S_RUN);
    idle(S_RUN);
    @(negedge clk);
    checks++;
    if (a_stall_cnt !== exp_stall) begin failures++; $display("FAIL lu_stall_total got=%0d want=%0d", a_stall_cnt, exp_stall); end
  endtask

  task automatic test_no_false_hazard;
    cyc(1'b1, I_ADD0,  1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_DEF, S_RUN); // load to x0
    cyc(1'b1, I_LUI1,  1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_DEF, S_RUN);
    cyc(1'b1, I_LUI,   1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_DEF, S_RUN);
    cyc(1'b1, I_AUIPC, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_DEF, S_RUN);
    cyc(1'b1, I_JAL,   1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_DEF, S_RUN);
    cyc(1'b0, I_ADD,   1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_DEF, S_RUN); // ID invalid
    cyc(1'b1, I_ADD,   1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_DEF, S_RUN); // EX invalid
    cyc(1'b1, I_ADD,   1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_DEF, S_RUN); // EX not a load
    idle(S_RUN);
  endtask

  task automatic test_branch;
    cyc(1'b1, I_ADD, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_BR, S_RUN);
    idle(S_RUN);
    @(negedge clk);
    checks++;
    if (a_flush_cnt !== 16'd1) begin failures++; $display("FAIL br_flush_cnt got=%0d want=1", a_flush_cnt); end
    // branch resolved while in LDUSE
    cyc(1'b1, I_ADD, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU, S_RUN);
    cyc(1'b1, I_ADD, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_BR, S_LDU);
    idle(S_RUN);
    @(negedge clk);
    checks += 2;
    if (a_flush_cnt !== 16'd2) begin failures++; $display("FAIL br_ldu_flush got=%0d want=2", a_flush_cnt); end
    if (a_stall_cnt !== exp_stall) begin failures++; $display("FAIL br_stall got=%0d want=%0d", a_stall_cnt, exp_stall); end
  endtask

  task automatic test_mem_wait;
    // MH + branch + LU together: hold for 3 cycles, branch flush on ack
    for (int i = 0; i < 3; i++)
      cyc(1'b1, I_ADD, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, C_HOLD, (i == 0) ? S_RUN : S_MW);
    cyc(1'b1, I_ADD, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, C_BR, S_MW);
    idle(S_RUN);
    // same-cycle ack: no stall
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_DEF, S_RUN);
    idle(S_RUN);
    // load-use held during the wait is acted on in the ack cycle
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_HOLD, S_RUN);
    cyc(1'b1, I_ADD, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, C_LU, S_MW);
    cyc(1'b1, I_ADD, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_DEF, S_LDU);
    idle(S_RUN);
    // memory hold entered from LDUSE
    cyc(1'b1, I_ADD, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU, S_RUN);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_HOLD, S_LDU);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_DEF, S_MW);
    idle(S_RUN);
    @(negedge clk);
    checks += 2;
    if (a_stall_cnt !== exp_stall) begin failures++; $display("FAIL mw_stall got=%0d want=%0d", a_stall_cnt, exp_stall); end
    if (a_flush_cnt !== exp_flush) begin failures++; $display("FAIL mw_flush got=%0d want=%0d", a_flush_cnt, exp_flush); end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_HOLD, (i == 0) ? S_RUN : S_MW);
    @(negedge clk);
    checks++;
    if (b_mem_timeout !== 1'b0) begin failures++; $display("FAIL to_early got=%b want=0", b_mem_timeout); end
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_HOLD, S_MW);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_DEF, S_MW);
    @(negedge clk);
    checks += 2;
    if (b_mem_timeout !== 1'b1) begin failures++; $display("FAIL to_set got=%b want=1", b_mem_timeout); end
    if (a_mem_timeout !== 1'b0) begin failures++; $display("FAIL to_main_early got=%b want=0", a_mem_timeout); end
    idle(S_RUN);
    idle(S_RUN);
    @(negedge clk);
    checks++;
    if (b_mem_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b want=1", b_mem_timeout); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 20; i++)
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_HOLD, (i == 0) ? S_RUN : S_MW);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_DEF, S_MW);
    idle(S_RUN);
    @(negedge clk);
    checks += 2;
    if (b_stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_stall_small got=%0d want=15", b_stall_cnt); end
    if (a_stall_cnt !== exp_stall) begin failures++; $display("FAIL sat_stall_main got=%0d want=%0d", a_stall_cnt, exp_stall); end
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_BR, S_RUN);
    idle(S_RUN);
    @(negedge clk);
    checks += 2;
    if (b_flush_cnt !== 4'd15) begin failures++; $display("FAIL sat_flush_small got=%0d want=15", b_flush_cnt); end
    if (a_flush_cnt !== exp_flush) begin failures++; $display("FAIL sat_flush_main got=%0d want=%0d", a_flush_cnt, exp_flush); end
    // long wait trips the default 64-cycle timeout
    for (int i = 0; i < 70; i++)
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_HOLD, (i == 0) ? S_RUN : S_MW);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_DEF, S_MW);
    idle(S_RUN);
    @(negedge clk);
    checks++;
    if (a_mem_timeout !== 1'b1) begin failures++; $display("FAIL to_main got=%b want=1", a_mem_timeout); end
  endtask

  task automatic test_reset_mid_wait;
    cyc(1'b1, I_ADD, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, C_HOLD, S_RUN);
    cyc(1'b1, I_ADD, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, C_HOLD, S_MW);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (a_state !== S_RUN || b_state !== S_RUN) begin
      failures++; $display("FAIL rmw_state got=%0d/%0d want=0", a_state, b_state);
    end
    if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin
      failures++; $display("FAIL rmw_cnt got=%0d/%0d want=0/0", a_stall_cnt, a_flush_cnt);
    end
    if (b_stall_cnt !== 4'd0 || b_flush_cnt !== 4'd0) begin
      failures++; $display("FAIL rmw_small_cnt got=%0d/%0d want=0/0", b_stall_cnt, b_flush_cnt);
    end
    if (a_mem_timeout !== 1'b0 || b_mem_timeout !== 1'b0) begin
      failures++; $display("FAIL rmw_timeout got=%b/%b want=0", a_mem_timeout, b_mem_timeout);
    end
    if (a_ctl !== C_DEF || b_ctl !== C_DEF) begin
      failures++; $display("FAIL rmw_ctl got=%b/%b want=%b", a_ctl, b_ctl, C_DEF);
    end
    id_vld = 1'b0; ex_vld = 1'b0; ex_is_load = 1'b0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    exp_stall = '0; exp_flush = '0; exp_stall_s = '0; exp_flush_s = '0;
    @(negedge clk); rst_n = 1'b1;
    idle(S_RUN);
    cyc(1'b1, I_ADD, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU, S_RUN);
    idle(S_LDU);
    idle(S_RUN);
    @(negedge clk);
    checks += 2;
    if (a_stall_cnt !== 16'd1 || b_stall_cnt !== 4'd1) begin
      failures++; $display("FAIL rmw_restart got=%0d/%0d want=1/1", a_stall_cnt, b_stall_cnt);
    end
    if (a_flush_cnt !== 16'd0) begin failures++; $display("FAIL rmw_no_pending_br got=%0d want=0", a_flush_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    id_vld = 1'b0; id_instr = 32'h0; ex_vld = 1'b0; ex_is_load = 1'b0; ex_rd_addr = 5'd0;
    ex_br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    exp_stall = '0; exp_flush = '0; exp_stall_s = '0; exp_flush_s = '0;
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_reset_mid_wait();
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL sb_drain left=%0d want=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t want=finish before limit", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
